// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: command FIFO plus one-at-a-time sequencer for the single-port register memory.
// Optional build macro MEM_REQ_TIMEOUT_EN adds a request-wait timeout that returns an error response.
//
//   state   | meaning
//   IDLE    | no transaction; pops the FIFO head once memory ready is low
//   REQ     | request driven to memory, waiting for ready (or timeout)
//   RESP    | response presented to host, waiting for rsp_ready_i
module mem_req_ctrl #(
    parameter int AWIDTH     = 4,
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [AWIDTH-1:0] cmd_addr_i,
    input  logic [DWIDTH-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_we_o,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_valid_o,
    output logic              mem_wr_en_o,
    output logic              mem_rd_en_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              busy_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = 1 + AWIDTH + DWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;

    logic [EW-1:0]     fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [EW-1:0]     head;

    logic              req_we_q, req_we_d;
    logic [AWIDTH-1:0] req_addr_q, req_addr_d;
    logic [DWIDTH-1:0] req_wdata_q, req_wdata_d;

    logic              rsp_we_q, rsp_we_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              req_done;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [TW-1:0]     tmo_inc;
    logic              req_tmo;
    logic              rsp_err_q, rsp_err_d;
`endif

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    // Held low while reset is asserted; otherwise depends only on occupancy.
    assign cmd_ready_o = rst_i & ~fifo_full;
    assign push        = cmd_valid_i & cmd_ready_o;
    assign head        = fifo_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {cmd_we_i, cmd_addr_i, cmd_wdata_i};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
`ifdef MEM_REQ_TIMEOUT_EN
    assign tmo_inc = tmo_cnt_q + TW'(1);
`endif

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        req_done = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
        req_tmo  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A ready still high from the previous transfer must not complete the next one.
                if (!fifo_empty && !mem_ready_i) begin
                    pop     = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ready_i) begin
                    req_done = 1'b1;
                    state_d  = ST_RESP;
                end
`ifdef MEM_REQ_TIMEOUT_EN
                else if (tmo_inc == TW'(TIMEOUT)) begin
                    req_tmo = 1'b1;
                    state_d = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_valid_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_rd_en_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            ST_REQ: begin
                mem_valid_o = 1'b1;
                mem_wr_en_o = req_we_q;
                mem_rd_en_o = ~req_we_q;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE) | ~fifo_empty;
    assign mem_addr_o  = req_addr_q;
    assign mem_wdata_o = req_wdata_q;
    assign rsp_we_o    = rsp_we_q;
    assign rsp_rdata_o = rsp_rdata_q;

    // ------------------------------------------------------------------
    // Request / response holding registers
    // ------------------------------------------------------------------
    always_comb begin
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        if (pop) begin
            {req_we_d, req_addr_d, req_wdata_d} = head;
        end
    end

    always_comb begin
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        if (req_done) begin
            rsp_we_d    = req_we_q;
            rsp_rdata_d = req_we_q ? '0 : mem_rdata_i;
        end
`ifdef MEM_REQ_TIMEOUT_EN
        if (req_tmo) begin
            rsp_we_d    = req_we_q;
            rsp_rdata_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Request timeout
    // ------------------------------------------------------------------
`ifdef MEM_REQ_TIMEOUT_EN
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        rsp_err_d = rsp_err_q;
        if (pop) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ST_REQ) && !mem_ready_i) begin
            tmo_cnt_d = tmo_inc;
        end
        if (req_done) begin
            rsp_err_d = 1'b0;
        end else if (req_tmo) begin
            rsp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    // No timeout path in this build: the error flag is constant 0.
    assign rsp_err_o = (TIMEOUT < 0);
`endif

endmodule
